ex_mem_stage: RTL and testbench

EX/MEM pipeline stage of the 5-stage MIPS core. It sits directly downstream of the ID/EX control register and the ALU, and latches the EX-stage control bits and datapath results. It resolves beq/bne/jump into a PC redirect plus a flush pulse. It also runs the data-memory request/acknowledge handshake, stalling upstream until the access completes or times out.

---
 rtl/ex_mem_stage.sv | 198 +++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register of the 5-stage MIPS core: latches EX results, resolves
// branches and jumps into a one-cycle redirect, and runs the data-memory handshake.
module ex_mem_stage #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_jump,
    input  logic        i_branch,
    input  logic        i_bne,
    input  logic        i_memToReg,
    input  logic        i_memWrite,
    input  logic        i_memRead,
    input  logic        i_regWrite,
    input  logic        i_zero,
    input  logic [31:0] i_aluResult,
    input  logic [31:0] i_writeData,
    input  logic [4:0]  i_writeReg,
    input  logic [31:0] i_branchTarget,
    input  logic [31:0] i_jumpTarget,
    input  logic        i_dmemAck,
    input  logic [31:0] i_dmemRdata,
    output logic        o_valid,
    output logic        o_memToReg,
    output logic        o_memWrite,
    output logic        o_memRead,
    output logic        o_regWrite,
    output logic [31:0] o_aluResult,
    output logic [31:0] o_writeData,
    output logic [4:0]  o_writeReg,
    output logic [31:0] o_readData,
    output logic        o_pcSrc,
    output logic [31:0] o_pcTarget,
    output logic        o_flush,
    output logic        o_dmemReq,
    output logic        o_dmemWe,
    output logic [31:0] o_dmemAddr,
    output logic [31:0] o_dmemWdata,
    output logic        o_busy,
    output logic        o_memErr
);

    // state  | meaning
    // S_IDLE | capturing one instruction per edge
    // S_WAIT | data-memory request outstanding, pipeline frozen
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic               mem_write_q, mem_write_d;
    logic               mem_read_q, mem_read_d;
    logic               reg_write_q, reg_write_d;
    logic [31:0]        alu_result_q, alu_result_d;
    logic [31:0]        write_data_q, write_data_d;
    logic [4:0]         write_reg_q, write_reg_d;
    logic [31:0]        read_data_q, read_data_d;
    logic               pc_src_q, pc_src_d;
    logic [31:0]        pc_target_q, pc_target_d;
    logic               dmem_req_q, dmem_req_d;
    logic               dmem_we_q, dmem_we_d;
    logic               mem_err_q, mem_err_d;
    logic               taken;

    assign taken = i_jump | (i_branch & i_zero) | (i_bne & ~i_zero);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        mem_to_reg_d = mem_to_reg_q;
        mem_write_d  = mem_write_q;
        mem_read_d   = mem_read_q;
        reg_write_d  = reg_write_q;
        alu_result_d = alu_result_q;
        write_data_d = write_data_q;
        write_reg_d  = write_reg_q;
        read_data_d  = read_data_q;
        pc_src_d     = 1'b0;
        pc_target_d  = pc_target_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        mem_err_d    = mem_err_q;

        if (state_q == S_IDLE) begin
            // The instruction behind a redirect is on the wrong path and is squashed here.
            if (!i_valid || pc_src_q) begin
                valid_d      = 1'b0;
                mem_to_reg_d = 1'b0;
                mem_write_d  = 1'b0;
                mem_read_d   = 1'b0;
                reg_write_d  = 1'b0;
                alu_result_d = '0;
                write_data_d = '0;
                write_reg_d  = '0;
            end else begin
                valid_d      = 1'b1;
                mem_to_reg_d = i_memToReg;
                mem_write_d  = i_memWrite;
                mem_read_d   = i_memRead;
                reg_write_d  = i_regWrite;
                alu_result_d = i_aluResult;
                write_data_d = i_writeData;
                write_reg_d  = i_writeReg;
                if (taken) begin
                    pc_src_d    = 1'b1;
                    pc_target_d = i_jump ? i_jumpTarget : i_branchTarget;
                end
                if (i_memRead || i_memWrite) begin
                    state_d    = S_WAIT;
                    dmem_req_d = 1'b1;
                    dmem_we_d  = i_memWrite;
                    cnt_d      = '0;
                end
            end
        end else begin
            if (i_dmemAck) begin
                if (!dmem_we_q) begin
                    read_data_d = i_dmemRdata;
                end
                dmem_req_d = 1'b0;
                state_d    = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
                // Abort: the load result is meaningless, so suppress its writeback.
                dmem_req_d  = 1'b0;
                mem_err_d   = 1'b1;
                read_data_d = '0;
                reg_write_d = 1'b0;
                state_d     = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_result_q <= '0;
            write_data_q <= '0;
            write_reg_q  <= '0;
            read_data_q  <= '0;
            pc_src_q     <= 1'b0;
            pc_target_q  <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            reg_write_q  <= reg_write_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            write_reg_q  <= write_reg_d;
            read_data_q  <= read_data_d;
            pc_src_q     <= pc_src_d;
            pc_target_q  <= pc_target_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            mem_err_q    <= mem_err_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_memToReg  = mem_to_reg_q;
    assign o_memWrite  = mem_write_q;
    assign o_memRead   = mem_read_q;
    assign o_regWrite  = reg_write_q;
    assign o_aluResult = alu_result_q;
    assign o_writeData = write_data_q;
    assign o_writeReg  = write_reg_q;
    assign o_readData  = read_data_q;
    assign o_pcSrc     = pc_src_q;
    assign o_flush     = pc_src_q;
    assign o_pcTarget  = pc_target_q;
    assign o_dmemReq   = dmem_req_q;
    assign o_dmemWe    = dmem_we_q;
    assign o_dmemAddr  = alu_result_q;
    assign o_dmemWdata = write_data_q;
    assign o_busy      = (state_q == S_WAIT);
    assign o_memErr    = mem_err_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: pass-through, branch/jump redirect, load/store
// handshake, timeout abort and asynchronous reset during an access.
module tb_ex_mem_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid, i_jump, i_branch, i_bne, i_memToReg, i_memWrite, i_memRead;
    logic        i_regWrite, i_zero, i_dmemAck;
    logic [31:0] i_aluResult, i_writeData, i_branchTarget, i_jumpTarget, i_dmemRdata;
    logic [4:0]  i_writeReg;
    logic        o_valid, o_memToReg, o_memWrite, o_memRead, o_regWrite;
    logic [31:0] o_aluResult, o_writeData, o_readData, o_pcTarget, o_dmemAddr, o_dmemWdata;
    logic [4:0]  o_writeReg;
    logic        o_pcSrc, o_flush, o_dmemReq, o_dmemWe, o_busy, o_memErr;

    int checks = 0;
    int errors = 0;
    int req_cycles;

    always #5 i_clk = ~i_clk;

    ex_mem_stage #(.TIMEOUT(15), .CNT_W(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_jump(i_jump),
        .i_branch(i_branch), .i_bne(i_bne), .i_memToReg(i_memToReg),
        .i_memWrite(i_memWrite), .i_memRead(i_memRead), .i_regWrite(i_regWrite),
        .i_zero(i_zero), .i_aluResult(i_aluResult), .i_writeData(i_writeData),
        .i_writeReg(i_writeReg), .i_branchTarget(i_branchTarget),
        .i_jumpTarget(i_jumpTarget), .i_dmemAck(i_dmemAck), .i_dmemRdata(i_dmemRdata),
        .o_valid(o_valid), .o_memToReg(o_memToReg), .o_memWrite(o_memWrite),
        .o_memRead(o_memRead), .o_regWrite(o_regWrite), .o_aluResult(o_aluResult),
        .o_writeData(o_writeData), .o_writeReg(o_writeReg), .o_readData(o_readData),
        .o_pcSrc(o_pcSrc), .o_pcTarget(o_pcTarget), .o_flush(o_flush),
        .o_dmemReq(o_dmemReq), .o_dmemWe(o_dmemWe), .o_dmemAddr(o_dmemAddr),
        .o_dmemWdata(o_dmemWdata), .o_busy(o_busy), .o_memErr(o_memErr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_in();
        i_valid = 0; i_jump = 0; i_branch = 0; i_bne = 0; i_memToReg = 0;
        i_memWrite = 0; i_memRead = 0; i_regWrite = 0; i_zero = 0; i_dmemAck = 0;
        i_aluResult = 0; i_writeData = 0; i_writeReg = 0; i_branchTarget = 0;
        i_jumpTarget = 0; i_dmemRdata = 0;
    endtask

    task automatic alu_op(input logic [31:0] res, input logic [4:0] rd);
        clear_in();
        i_valid = 1; i_regWrite = 1; i_aluResult = res; i_writeReg = rd;
    endtask

    initial begin
        clear_in();
        i_rst_n = 0;
        #12;
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_req", o_dmemReq, 0);
        chk("rst_err", o_memErr, 0);
        i_rst_n = 1;
        step();

        // ALU pass-through
        alu_op(32'h10, 5'd8);
        step();
        chk("alu_valid", o_valid, 1);
        chk("alu_regwr", o_regWrite, 1);
        chk("alu_res", o_aluResult, 32'h10);
        chk("alu_wreg", o_writeReg, 8);
        chk("alu_busy", o_busy, 0);
        chk("alu_req", o_dmemReq, 0);
        chk("alu_pcsrc", o_pcSrc, 0);

        // beq taken
        clear_in();
        i_valid = 1; i_branch = 1; i_zero = 1;
        i_branchTarget = 32'h0040_0020; i_jumpTarget = 32'h0050_0000;
        step();
        chk("beq_pcsrc", o_pcSrc, 1);
        chk("beq_flush", o_flush, 1);
        chk("beq_tgt", o_pcTarget, 32'h0040_0020);
        alu_op(32'h44, 5'd3);
        step();
        chk("squash_valid", o_valid, 0);
        chk("squash_regwr", o_regWrite, 0);
        chk("squash_pcsrc", o_pcSrc, 0);
        chk("squash_flush", o_flush, 0);

        // bne with zero=1: not taken, target holds
        clear_in();
        i_valid = 1; i_bne = 1; i_zero = 1; i_branchTarget = 32'h0040_0080;
        step();
        chk("bne_nt_pcsrc", o_pcSrc, 0);
        chk("bne_nt_tgt", o_pcTarget, 32'h0040_0020);
        chk("bne_nt_valid", o_valid, 1);

        // bne with zero=0: taken
        i_zero = 0;
        step();
        chk("bne_t_pcsrc", o_pcSrc, 1);
        chk("bne_t_tgt", o_pcTarget, 32'h0040_0080);
        clear_in();
        step();

        // jump has priority over branch
        clear_in();
        i_valid = 1; i_jump = 1; i_branch = 1; i_zero = 1;
        i_branchTarget = 32'h0040_0100; i_jumpTarget = 32'h0050_0000;
        step();
        chk("jmp_pcsrc", o_pcSrc, 1);
        chk("jmp_tgt", o_pcTarget, 32'h0050_0000);
        clear_in();
        step();
        chk("jmp_clear", o_pcSrc, 0);

        // Load, ack after 3 WAIT cycles
        clear_in();
        i_valid = 1; i_memRead = 1; i_memToReg = 1; i_regWrite = 1;
        i_aluResult = 32'h100; i_writeReg = 5'd9;
        step();
        req_cycles = 0;
        chk("ld_busy0", o_busy, 1);
        chk("ld_we", o_dmemWe, 0);
        chk("ld_addr", o_dmemAddr, 32'h100);
        alu_op(32'h999, 5'd4);
        for (int i = 0; i < 2; i++) begin
            if (o_dmemReq) req_cycles++;
            step();
            chk("ld_hold_busy", o_busy, 1);
            chk("ld_hold_addr", o_dmemAddr, 32'h100);
            chk("ld_hold_wreg", o_writeReg, 9);
        end
        if (o_dmemReq) req_cycles++;
        i_dmemAck = 1; i_dmemRdata = 32'hDEAD_BEEF;
        step();
        chk("ld_req_cycles", req_cycles, 3);
        chk("ld_req_off", o_dmemReq, 0);
        chk("ld_busy_off", o_busy, 0);
        chk("ld_rdata", o_readData, 32'hDEAD_BEEF);
        chk("ld_nocap", o_aluResult, 32'h100);
        chk("ld_regwr", o_regWrite, 1);
        i_dmemAck = 0;
        step();
        chk("ld_next_cap", o_aluResult, 32'h999);

        // Store, ack after 1 cycle
        clear_in();
        i_valid = 1; i_memWrite = 1; i_aluResult = 32'h200; i_writeData = 32'h1234_5678;
        step();
        chk("st_we", o_dmemWe, 1);
        chk("st_req", o_dmemReq, 1);
        chk("st_wdata", o_dmemWdata, 32'h1234_5678);
        clear_in();
        i_dmemAck = 1; i_dmemRdata = 32'h5555_AAAA;
        step();
        chk("st_req_off", o_dmemReq, 0);
        chk("st_rdata_keep", o_readData, 32'hDEAD_BEEF);

        // ack while idle is ignored
        alu_op(32'h20, 5'd2);
        i_dmemAck = 1; i_dmemRdata = 32'h0BAD_0BAD;
        step();
        chk("idle_ack_rdata", o_readData, 32'hDEAD_BEEF);
        chk("idle_ack_busy", o_busy, 0);

        // Timeout with no ack
        clear_in();
        i_valid = 1; i_memRead = 1; i_regWrite = 1; i_aluResult = 32'h300;
        step();
        clear_in();
        req_cycles = 0;
        for (int i = 0; i < 40 && o_dmemReq; i++) begin
            req_cycles++;
            step();
        end
        chk("to_req_cycles", req_cycles, 15);
        chk("to_req_off", o_dmemReq, 0);
        chk("to_err", o_memErr, 1);
        chk("to_regwr", o_regWrite, 0);
        chk("to_rdata", o_readData, 0);
        chk("to_busy", o_busy, 0);
        alu_op(32'h77, 5'd7);
        step();
        chk("to_resume", o_aluResult, 32'h77);
        chk("to_err_sticky", o_memErr, 1);

        // Reset during an access
        clear_in();
        i_valid = 1; i_memRead = 1; i_regWrite = 1; i_aluResult = 32'h400;
        step();
        chk("rm_busy", o_busy, 1);
        #2;
        i_rst_n = 0;
        #1;
        chk("rm_busy0", o_busy, 0);
        chk("rm_req0", o_dmemReq, 0);
        chk("rm_err0", o_memErr, 0);
        chk("rm_valid0", o_valid, 0);
        chk("rm_alu0", o_aluResult, 0);
        #3;
        i_rst_n = 1;
        alu_op(32'h88, 5'd5);
        step();
        chk("rm_cap_valid", o_valid, 1);
        chk("rm_cap_alu", o_aluResult, 32'h88);
        chk("rm_cap_busy", o_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
